// File: rtl/eq_pkg.sv
// Shared types and defaults for the equalizer stream controller.
package eq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    CFG
  } eq_ctrl_state_t;

  localparam int unsigned SIZE_DEF       = 44;
  localparam int unsigned SAMPLES_DEF    = 2048;
  localparam int unsigned COEFF_BITS_DEF = 8;
  localparam int unsigned CFG_BURST_DEF  = 64;

  // Width of an index able to address n entries (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eq_out_stage.sv
// One-entry valid/ready output register carrying {data, index, last}.
module eq_out_stage
  import eq_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEF,
  parameter int unsigned IDXW = idx_width(SAMPLES_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [SIZE-1:0] data_in,
  input  logic [IDXW-1:0] index_in,
  input  logic            last_in,
  input  logic            ready,
  output logic            valid,
  output logic [SIZE-1:0] data,
  output logic [IDXW-1:0] index,
  output logic            last,
  output logic            free
);

  assign free = !valid | ready;

  // Capture a new bin on load; otherwise drain once the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      index <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_in;
      index <= index_in;
      last  <= last_in;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/eq_stream_ctrl.sv
// Frame sequencer for the per-bin equalizer: drives the bin index, registers
// the equalized result onto the output stream, and confines host coefficient
// writes to the gaps between frames.
module eq_stream_ctrl
  import eq_pkg::*;
#(
  parameter int unsigned SIZE       = SIZE_DEF,
  parameter int unsigned SAMPLES    = SAMPLES_DEF,
  parameter int unsigned COEFF_BITS = COEFF_BITS_DEF,
  parameter int unsigned CFG_BURST  = CFG_BURST_DEF,
  localparam int unsigned IDXW      = idx_width(SAMPLES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [SIZE-1:0]       s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [SIZE-1:0]       m_data,
  output logic [IDXW-1:0]       m_index,
  output logic                  m_last,
  output logic [IDXW-1:0]       eq_input_index,
  output logic [SIZE-1:0]       eq_data_in,
  input  logic [SIZE-1:0]       eq_data_out,
  output logic                  eq_coeff_wr_en,
  output logic [IDXW-1:0]       eq_coeff_index,
  output logic [COEFF_BITS-1:0] eq_coeff_in,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [IDXW-1:0]       cfg_index,
  input  logic [COEFF_BITS-1:0] cfg_coeff,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output logic                  err_len
);

  localparam int unsigned BW = idx_width(CFG_BURST + 1);
  localparam logic [IDXW-1:0] IDX_MAX   = IDXW'(SAMPLES - 1);
  localparam logic [BW-1:0]   BURST_MAX = BW'(CFG_BURST - 1);

  eq_ctrl_state_t  state;
  logic [IDXW-1:0] idx;
  logic [BW-1:0]   burst_cnt;
  logic            cfg_prio;
  logic            out_free;
  logic            accept;
  logic            idx_last;

  assign idx_last = (idx == IDX_MAX);
  assign s_ready  = out_free &
                    ((state == STREAM) | ((state == IDLE) & !(cfg_valid & cfg_prio)));
  assign accept   = s_valid & s_ready;

  assign cfg_ready      = (state == CFG);
  assign eq_coeff_wr_en = cfg_ready & cfg_valid;
  assign eq_coeff_index = cfg_index;
  assign eq_coeff_in    = cfg_coeff;

  assign eq_input_index = idx;
  assign eq_data_in     = s_data;

  assign busy = (state != IDLE) | m_valid;

  // Frame FSM, bin counter and config/stream arbiter. An accept can only occur
  // in IDLE/STREAM and a config grant only when no accept happens, so the two
  // branches never compete for the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      burst_cnt   <= '0;
      cfg_prio    <= 1'b1;
      frame_count <= '0;
      err_len     <= 1'b0;
    end else if (accept) begin
      if (s_last != idx_last) err_len <= 1'b1;
      if (idx_last) begin
        idx         <= '0;
        frame_count <= frame_count + 16'd1;
        cfg_prio    <= 1'b1;
        state       <= IDLE;
      end else begin
        idx   <= idx + IDXW'(1);
        state <= STREAM;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid && (cfg_prio || !s_valid)) state <= CFG;
        end
        CFG: begin
          if (!cfg_valid) begin
            state     <= IDLE;
            burst_cnt <= '0;
          end else if (burst_cnt == BURST_MAX) begin
            state     <= IDLE;
            burst_cnt <= '0;
            cfg_prio  <= 1'b0;
          end else begin
            burst_cnt <= burst_cnt + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  eq_out_stage #(
    .SIZE (SIZE),
    .IDXW (IDXW)
  ) u_out_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .data_in  (eq_data_out),
    .index_in (idx),
    .last_in  (idx_last),
    .ready    (m_ready),
    .valid    (m_valid),
    .data     (m_data),
    .index    (m_index),
    .last     (m_last),
    .free     (out_free)
  );

endmodule
